hex_display_arbiter: RTL and testbench
======================================

# hex_display_arbiter

Shares the 8-digit multiplexed hex display between two 32-bit requesters. Generates the digit scan timing, so `hex_to_seg` only decodes the nibble this block presents. Uses round-robin arbitration with a minimum ownership time in whole display frames. Latches owner data only at frame boundaries to prevent tearing, and inserts one blank digit period on every ownership change.

## Interface
- `SCAN_DIV`, default 1024: clock cycles per digit period; legal values ≥ 2.
- `HOLD_FRAMES`, default 16: minimum frames an owner keeps the display while it still requests; legal values ≥ 1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  2: per-requester display request, level.
- `data0`, `data1`  in  32 each: requester values; digit k is bits [4k+3:4k].
- `grant`  out  2: one-hot current owner, registered.
- `anodes`  out  8: one-hot active-high digit enable; all zero when blank.
- `nibble`  out  4: hex digit for the enabled anode, fed to `hex_to_seg`.
- `frame_start`  out  1: one-cycle pulse when digit index returns to 0 while owned.

## Operation
- Prescaler `cnt` runs 0..SCAN_DIV-1. `tick` = (`cnt` == SCAN_DIV-1). The digit index `idx` (3 bits) increments on `tick` and wraps 7→0. A frame boundary is `tick` with `idx` == 7.
- Snapshot register `snap` (32 bits): `nibble` = `snap`[4·`idx`+3 : 4·`idx`]. `anodes` = 1 << `idx` in OWN, 0 otherwise.
- Round-robin pointer `rr` (reset 0) names the favoured requester when both request.
- The FSM has three states:
  - **IDLE**: `grant` = 0, `anodes` = 0, `nibble` = 0.
    - If any `req` bit is set, go to OWN with winner w. Winner is the sole requester, or `rr` if both request.
    - On entry to OWN: `snap` ← `data`w, `cnt` ← 0, `idx` ← 0, frame counter `fc` ← 0.
  - **OWN(w)**: `grant`[w] = 1.
    - At each frame boundary: `snap` ← `data`w, and `fc` increments, saturating at HOLD_FRAMES.
    - If `req`[w] drops (checked every cycle): `rr` ← 1-w. Go to SWITCH if `req`[1-w] is set, else go to IDLE.
    - Else, at a frame boundary where `fc` will equal HOLD_FRAMES and `req`[1-w] is set: `rr` ← 1-w, go to SWITCH.
  - **SWITCH**: `grant` = 0, `anodes` = 0, `nibble` = 0. Lasts exactly SCAN_DIV cycles; `cnt` is reset to 0 on entry.
    - At the end, pick a winner by the IDLE rule and enter OWN with the same entry actions.
    - If no `req` bit is set at that point, go to IDLE.
- Simultaneous events:
  - Owner release at a frame boundary beats the snapshot update: `snap` is not reloaded.
  - A new request arriving during SWITCH is considered at its end.
  - `req` changes in IDLE act on the next edge.
- Reset (asynchronous, including mid-frame or mid-SWITCH) clears everything at once: state IDLE, `cnt`, `idx`, `fc`, `snap`, `rr`, `grant`, `anodes`, `nibble` and `frame_start` all go to 0.

## Timing
- Grant latency from IDLE: `req` high at edge N gives `grant` and digit 0 enabled after edge N. `nibble` is `data`w[3:0] sampled at edge N.
- Each digit is enabled for exactly SCAN_DIV cycles. A frame is 8·SCAN_DIV cycles.
- Data changes become visible only at a frame boundary, or at a new grant.
- Release latency: `req`[w] low sampled at edge N gives `grant` = 0 and `anodes` = 0 after edge N.
- Blank gap between owners: exactly SCAN_DIV cycles.
- Worst-case wait for the non-owner while the owner holds: HOLD_FRAMES·8·SCAN_DIV + SCAN_DIV cycles from grant.
- `frame_start` is asserted in the cycle after each frame-boundary edge while in OWN. It is not asserted on grant entry.

## Test plan
Bench parameters: SCAN_DIV = 4, HOLD_FRAMES = 2.

- **Reset values.** Hold `rst_n` = 0 with `req` = 2'b11 → `grant` = 0, `anodes` = 0, `nibble` = 0. Release reset → `grant` = 2'b01 on the next edge (`rr` = 0).
- **Scan sequence.** Set `req` = 01, `data0` = 32'h89ABCDEF → `nibble` sequence F,E,D,C,B,A,9,8. Each value lasts 4 cycles with `anodes` 01,02,…,80, then wraps.
- **No tearing.** Change `data0` to 32'h12345678 mid-frame → the displayed value stays 89ABCDEF until the frame boundary, then shows 8,7,6,…
- **Hold and switch.** Owner 0 requesting; `req`[1] rises in frame 0 → `grant` = 01 for 64 cycles, then 00 with `anodes` = 0 for 4 cycles, then `grant` = 10 showing `data1`. After that, `req` = 11 → the next switch goes back to 0.
- **Early release.** Owner 1 drops `req` at cycle 5 of its ownership with `req`[0] high → `grant` = 0 next edge, 4 blank cycles, then `grant` = 01.
- **Mid-operation reset.** Pulse `rst_n` low for 1 cycle during SWITCH → outputs are 0 immediately. Afterwards, with `req` = 10, `grant` = 10 is issued from digit 0.

Source files
------------

// File: rtl/hex_display_arbiter_if.sv
// Bundle between the two display requesters and the hex display arbiter.
// Requester side drives req/data, arbiter side drives grant and scan outputs.
interface hex_display_arbiter_if;
    logic [1:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [1:0]  grant;
    logic [7:0]  anodes;
    logic [3:0]  nibble;
    logic        frame_start;

    modport master (
        output req, data0, data1,
        input  grant, anodes, nibble, frame_start
    );

    modport slave (
        input  req, data0, data1,
        output grant, anodes, nibble, frame_start
    );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the 8-digit hex display with frame-aligned snapshots,
// minimum hold time in frames and one blank digit period between owners.
module hex_display_arbiter #(
    parameter int SCAN_DIV    = 1024,
    parameter int HOLD_FRAMES = 16
) (
    input logic clk,
    input logic rst_n,
    hex_display_arbiter_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(HOLD_FRAMES + 1);
    localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FMAX = FW'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_t;

    state_t        state, state_n;
    logic          w, w_n;
    logic          rr, rr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [FW-1:0] fc, fc_n;
    logic [31:0]   snap, snap_n;
    logic          fs, fs_n;

    logic          tick, bound, win;
    logic [FW-1:0] fc_inc;
    logic [31:0]   own_data, win_data;

    assign tick     = (cnt == CMAX);
    assign bound    = tick && (idx == 3'd7);
    assign win      = (bus.req == 2'b11) ? rr : bus.req[1];
    assign win_data = win ? bus.data1 : bus.data0;
    assign own_data = w ? bus.data1 : bus.data0;
    assign fc_inc   = (fc == FMAX) ? fc : fc + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            w     <= 1'b0;
            rr    <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
            fc    <= '0;
            snap  <= '0;
            fs    <= 1'b0;
        end else begin
            state <= state_n;
            w     <= w_n;
            rr    <= rr_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            fc    <= fc_n;
            snap  <= snap_n;
            fs    <= fs_n;
        end
    end

    always_comb begin
        state_n = state;
        w_n     = w;
        rr_n    = rr;
        cnt_n   = cnt;
        idx_n   = idx;
        fc_n    = fc;
        snap_n  = snap;
        fs_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_n = OWN;
                    w_n     = win;
                    snap_n  = win_data;
                    cnt_n   = '0;
                    idx_n   = '0;
                    fc_n    = '0;
                end
            end
            OWN: begin
                cnt_n = tick ? '0 : cnt + 1'b1;
                idx_n = tick ? idx + 3'd1 : idx;
                if (!bus.req[w]) begin
                    rr_n    = ~w;
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = bus.req[~w] ? SWITCH : IDLE;
                end else if (bound) begin
                    fc_n = fc_inc;
                    // Hold expired and the other side waits: hand over.
                    if (fc_inc == FMAX && bus.req[~w]) begin
                        rr_n    = ~w;
                        cnt_n   = '0;
                        idx_n   = '0;
                        state_n = SWITCH;
                    end else begin
                        snap_n = own_data;
                        fs_n   = 1'b1;
                    end
                end
            end
            SWITCH: begin
                cnt_n = cnt + 1'b1;
                if (tick) begin
                    cnt_n = '0;
                    idx_n = '0;
                    fc_n  = '0;
                    if (|bus.req) begin
                        state_n = OWN;
                        w_n     = win;
                        snap_n  = win_data;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.grant       = (state == OWN) ? {w, ~w} : 2'b00;
    assign bus.anodes      = (state == OWN) ? (8'b1 << idx) : 8'b0;
    assign bus.nibble      = (state == OWN) ? snap[{idx, 2'b00} +: 4] : 4'b0;
    assign bus.frame_start = fs;
endmodule

// File: tb/tb_hex_display_arbiter.sv
// Randomised bench for hex_display_arbiter against a cycle-count model
// of ownership, blank gaps and frame-aligned snapshots.
module tb_hex_display_arbiter;
    localparam int SD   = 4;
    localparam int HOLD = 2;
    localparam int FRM  = 8 * SD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    hex_display_arbiter_if bus ();

    hex_display_arbiter #(
        .SCAN_DIV    (SD),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // mode: 0 idle, 1 owned by w, 2 blank gap; t counts cycles in mode
    typedef struct {
        int          mode;
        int          w;
        int          t;
        logic [31:0] snap;
        int          rr;
        bit          fs;
    } ms_t;

    ms_t m;

    function automatic ms_t grant_to(ms_t s, logic [1:0] r,
                                     logic [31:0] d0, logic [31:0] d1);
        ms_t n = s;
        n.w    = (r == 2'b11) ? s.rr : (r[1] ? 1 : 0);
        n.mode = 1;
        n.t    = 0;
        n.snap = (n.w == 1) ? d1 : d0;
        return n;
    endfunction

    function automatic ms_t step(ms_t s, logic [1:0] r,
                                 logic [31:0] d0, logic [31:0] d1);
        ms_t n = s;
        int  o;
        n.fs = 0;
        if (s.mode == 0) begin
            if (r != 2'b00) n = grant_to(n, r, d0, d1);
        end else if (s.mode == 2) begin
            if (s.t == SD - 1) begin
                if (r != 2'b00) n = grant_to(n, r, d0, d1);
                else n.mode = 0;
            end else n.t = s.t + 1;
        end else begin
            o = 1 - s.w;
            if (!r[s.w]) begin
                n.rr   = o;
                n.mode = r[o] ? 2 : 0;
                n.t    = 0;
            end else if ((s.t + 1) % FRM == 0) begin
                if ((s.t + 1) / FRM >= HOLD && r[o]) begin
                    n.rr   = o;
                    n.mode = 2;
                    n.t    = 0;
                end else begin
                    n.snap = (s.w == 1) ? d1 : d0;
                    n.fs   = 1;
                    n.t    = s.t + 1;
                end
            end else n.t = s.t + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{0, 0, 0, 32'h0, 0, 1'b0};
        else m <= step(m, bus.req, bus.data0, bus.data1);
    end

    function automatic int digit(ms_t s);
        return (s.t / SD) % 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs();
        logic [31:0] eg, ea, en;
        eg = 0;
        ea = 0;
        en = 0;
        if (m.mode == 1) begin
            eg = (m.w == 1) ? 32'd2 : 32'd1;
            ea = 32'd1 << digit(m);
            en = (m.snap >> (4 * digit(m))) & 32'hF;
        end
        check("grant", 32'(bus.grant), eg);
        check("anodes", 32'(bus.anodes), ea);
        check("nibble", 32'(bus.nibble), en);
        check("frame_start", 32'(bus.frame_start), 32'(m.fs));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outs();
        end
    endtask

    initial begin
        int budget;
        bus.req   = 2'b11;
        bus.data0 = 32'h89ABCDEF;
        bus.data1 = 32'h0F1E2D3C;
        run(3);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_anodes", 32'(bus.anodes), 32'd0);
        rst_n = 1'b1;
        run(1);
        check("first_grant", 32'(bus.grant), 32'd1);
        check("first_nibble", 32'(bus.nibble), 32'hF);
        bus.req = 2'b01;
        run(10);
        bus.data0 = 32'h12345678;
        run(40);
        bus.req = 2'b11;
        run(150);

        budget = 400;
        while (budget > 0 && !(m.mode == 1 && m.w == 1 && m.t == 5)) begin
            run(1);
            budget--;
        end
        check("reach_owner1", 32'(budget > 0), 32'd1);
        bus.req = 2'b01;
        run(12);
        check("regrant0", 32'(bus.grant), 32'd1);

        bus.req = 2'b11;
        budget = 400;
        while (budget > 0 && m.mode != 2) begin
            run(1);
            budget--;
        end
        check("reach_switch", 32'(budget > 0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_grant", 32'(bus.grant), 32'd0);
        check("mrst_anodes", 32'(bus.anodes), 32'd0);
        check("mrst_nibble", 32'(bus.nibble), 32'd0);
        check("mrst_fs", 32'(bus.frame_start), 32'd0);
        bus.req = 2'b10;
        @(negedge clk);
        rst_n = 1'b1;
        run(1);
        check("post_grant", 32'(bus.grant), 32'd2);
        check("post_anodes", 32'(bus.anodes), 32'd1);
        run(20);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) bus.req = 2'($urandom);
            if ($urandom_range(0, 3) == 0) bus.data0 = $urandom;
            if ($urandom_range(0, 3) == 0) bus.data1 = $urandom;
            run(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
